// File: rtl/count_seq_checker_pkg.sv
// count_seq_checker_pkg: state encoding and default counter sequence bounds
package count_seq_checker_pkg;
  typedef enum logic [1:0] {ST_IDLE = 2'd0, ST_RUN = 2'd1, ST_ERROR = 2'd2} state_t;
  localparam int DEF_MAX_VAL = 7;
  localparam int DEF_WRAP_VAL = 3;
endpackage

// File: rtl/count_seq_checker_sat_counter.sv
// sat_counter: saturating incrementer with synchronous clear
module sat_counter #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         clr,
  input  logic         inc,
  output logic [W-1:0] q
);
  always_ff @(posedge clk)
    q <= (rst || clr) ? '0 : (inc && !(&q)) ? q + W'(1) : q;
endmodule

// File: rtl/count_seq_checker.sv
// count_seq_checker: checks a wrapping counter sequence, counts laps and errors
// Optional ERROR->RUN resync via COUNT_SEQ_CHECKER_RESYNC_EN.
module count_seq_checker
  import count_seq_checker_pkg::*;
#(
  parameter int WIDTH      = 3,
  parameter int MAX_VAL    = DEF_MAX_VAL,
  parameter int WRAP_VAL   = DEF_WRAP_VAL,
  parameter int LAP_W      = 8,
  parameter int ERR_W      = 4,
  parameter int RESYNC_LEN = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] count,
  output logic [1:0]       state,
  output logic             wrap_pulse,
  output logic [LAP_W-1:0] lap_count,
  output logic             err,
  output logic             err_sticky,
  output logic [ERR_W-1:0] err_count
);
  state_t st, nxt;
  logic [WIDTH-1:0] prev_q, exp_v;
  logic legal, lap_inc, err_inc, resync;
  assign exp_v = (prev_q == WIDTH'(MAX_VAL)) ? WIDTH'(WRAP_VAL) : prev_q + WIDTH'(1);
  assign legal = count == exp_v;
`ifdef COUNT_SEQ_CHECKER_RESYNC_EN
  localparam int GW = $clog2(RESYNC_LEN + 1);
  logic [GW-1:0] good;
  assign resync = legal && good == GW'(RESYNC_LEN - 1);
  sat_counter #(.W(GW)) u_good (
    .clk(clk), .rst(rst), .clr(st != ST_ERROR || !legal || resync), .inc(legal), .q(good)
  );
`else
  assign resync = 1'b0;
`endif
  always_comb begin
    err_inc = (st == ST_IDLE && count != '0) || (st == ST_RUN && !legal);
    lap_inc = st == ST_RUN && legal && prev_q == WIDTH'(MAX_VAL);
    nxt = (st == ST_IDLE) ? (count == '0 ? ST_RUN : ST_ERROR) :
          (st == ST_RUN)  ? (legal ? ST_RUN : ST_ERROR) :
                            (resync ? ST_RUN : ST_ERROR);
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      st         <= ST_IDLE;
      prev_q     <= '0;
      wrap_pulse <= 1'b0;
      err        <= 1'b0;
      err_sticky <= 1'b0;
    end else begin
      st         <= nxt;
      prev_q     <= count;
      wrap_pulse <= lap_inc;
      err        <= nxt == ST_ERROR;
      err_sticky <= err_sticky | err_inc;
    end
  end
  sat_counter #(.W(LAP_W)) u_lap (
    .clk(clk), .rst(rst), .clr(1'b0), .inc(lap_inc), .q(lap_count)
  );
  sat_counter #(.W(ERR_W)) u_err (
    .clk(clk), .rst(rst), .clr(1'b0), .inc(err_inc), .q(err_count)
  );
  assign state = st;
endmodule

// File: tb/tb_count_seq_checker.sv
// tb_count_seq_checker: table vectors plus scoreboarded reference model
module tb_count_seq_checker;
  logic clk = 1'b0, rst = 1'b1;
  logic [2:0] count = 3'd0;
  logic [1:0] state;
  logic wrap_pulse, err, err_sticky;
  logic [7:0] lap_count;
  logic [3:0] err_count;
  int checks = 0, errors = 0;

  count_seq_checker dut (
    .clk(clk), .rst(rst), .count(count), .state(state), .wrap_pulse(wrap_pulse),
    .lap_count(lap_count), .err(err), .err_sticky(err_sticky), .err_count(err_count)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [1:0] st; logic wrap; logic [7:0] lap; logic err; logic sticky; logic [3:0] errc;
  } exp_t;
  typedef struct {
    logic rst; logic [2:0] count; logic [1:0] st; logic wrap; logic [7:0] lap; logic err;
  } vec_t;

  exp_t sbq[$];
  logic [1:0] m_st = 2'd0;
  logic [2:0] m_prev = 3'd0;
  logic [7:0] m_lap = 8'd0;
  logic [3:0] m_errc = 4'd0;
  logic m_sticky = 1'b0, m_wrap = 1'b0;
  int m_good = 0;

  function automatic logic [2:0] nx(input logic [2:0] p);
    return (p == 3'd7) ? 3'd3 : p + 3'd1;
  endfunction

  task automatic chk(input string name, input int act, input int expv);
    checks++;
    if (act != expv) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, expv, $time);
    end
  endtask

  task automatic model(input logic r, input logic [2:0] c);
    exp_t e;
    logic [2:0] ex;
    ex = nx(m_prev);
    m_wrap = 1'b0;
    if (r) begin
      m_st = 2'd0; m_prev = 3'd0; m_lap = 8'd0; m_errc = 4'd0; m_sticky = 1'b0; m_good = 0;
    end else begin
      case (m_st)
        2'd0: begin
          if (c == 3'd0) m_st = 2'd1;
          else begin m_st = 2'd2; m_sticky = 1'b1; if (m_errc != 4'hf) m_errc++; end
        end
        2'd1: begin
          if (c == ex) begin
            m_wrap = m_prev == 3'd7;
            if (m_wrap && m_lap != 8'hff) m_lap++;
          end else begin
            m_st = 2'd2; m_sticky = 1'b1; m_good = 0;
            if (m_errc != 4'hf) m_errc++;
          end
        end
        default: begin
`ifdef COUNT_SEQ_CHECKER_RESYNC_EN
          if (c == ex) begin
            m_good++;
            if (m_good == 4) begin m_st = 2'd1; m_good = 0; end
          end else m_good = 0;
`endif
        end
      endcase
      m_prev = c;
    end
    e = '{m_st, m_wrap, m_lap, m_st == 2'd2, m_sticky, m_errc};
    sbq.push_back(e);
  endtask

  task automatic step(input logic r, input logic [2:0] c);
    exp_t e;
    @(negedge clk);
    rst = r;
    count = c;
    model(r, c);
    @(posedge clk);
    #1;
    if (sbq.size() == 0) begin
      checks++; errors++;
      $display("FAIL scoreboard: queue empty at %0t", $time);
    end else begin
      e = sbq.pop_front();
      chk("sb_state", state, e.st);
      chk("sb_wrap", wrap_pulse, e.wrap);
      chk("sb_lap", lap_count, e.lap);
      chk("sb_err", err, e.err);
      chk("sb_sticky", err_sticky, e.sticky);
      chk("sb_errc", err_count, e.errc);
    end
  endtask

  vec_t tbl[18];
  logic [2:0] p;

  initial begin
    tbl = '{
      '{1'b1, 3'd0, 2'd0, 1'b0, 8'd0, 1'b0}, '{1'b1, 3'd0, 2'd0, 1'b0, 8'd0, 1'b0},
      '{1'b1, 3'd0, 2'd0, 1'b0, 8'd0, 1'b0}, '{1'b1, 3'd0, 2'd0, 1'b0, 8'd0, 1'b0},
      '{1'b0, 3'd0, 2'd1, 1'b0, 8'd0, 1'b0}, '{1'b0, 3'd1, 2'd1, 1'b0, 8'd0, 1'b0},
      '{1'b0, 3'd2, 2'd1, 1'b0, 8'd0, 1'b0}, '{1'b0, 3'd3, 2'd1, 1'b0, 8'd0, 1'b0},
      '{1'b0, 3'd4, 2'd1, 1'b0, 8'd0, 1'b0}, '{1'b0, 3'd5, 2'd1, 1'b0, 8'd0, 1'b0},
      '{1'b0, 3'd6, 2'd1, 1'b0, 8'd0, 1'b0}, '{1'b0, 3'd7, 2'd1, 1'b0, 8'd0, 1'b0},
      '{1'b0, 3'd3, 2'd1, 1'b1, 8'd1, 1'b0}, '{1'b0, 3'd4, 2'd1, 1'b0, 8'd1, 1'b0},
      '{1'b0, 3'd5, 2'd1, 1'b0, 8'd1, 1'b0}, '{1'b0, 3'd6, 2'd1, 1'b0, 8'd1, 1'b0},
      '{1'b0, 3'd7, 2'd1, 1'b0, 8'd1, 1'b0}, '{1'b0, 3'd3, 2'd1, 1'b1, 8'd2, 1'b0}
    };
    for (int i = 0; i < 18; i++) begin
      step(tbl[i].rst, tbl[i].count);
      chk("tbl_state", state, tbl[i].st);
      chk("tbl_wrap", wrap_pulse, tbl[i].wrap);
      chk("tbl_lap", lap_count, tbl[i].lap);
      chk("tbl_err", err, tbl[i].err);
    end
    chk("tbl_errc", err_count, 0);

    // skip 6: 5 -> 7 is a sequence error
    step(1'b0, 3'd4); step(1'b0, 3'd5); step(1'b0, 3'd7);
    chk("skip_state", state, 2);
    chk("skip_err", err, 1);
    chk("skip_sticky", err_sticky, 1);
    chk("skip_errc", err_count, 1);
    step(1'b0, 3'd3);
    chk("err_nowrap", wrap_pulse, 0);
    step(1'b0, 3'd4); step(1'b0, 3'd5);
    chk("err_lap_held", lap_count, 2);

    // reset while in ERROR, then bad first sample
    step(1'b1, 3'd0); step(1'b1, 3'd0);
    chk("rst_err_state", state, 0);
    chk("rst_err_sticky", err_sticky, 0);
    chk("rst_err_errc", err_count, 0);
    chk("rst_err_lap", lap_count, 0);
    step(1'b0, 3'd2);
    chk("idle_bad_state", state, 2);
    chk("idle_bad_errc", err_count, 1);

    // reset mid-lap, then one clean lap
    step(1'b1, 3'd0);
    for (int i = 0; i <= 5; i++) step(1'b0, 3'(i));
    step(1'b1, 3'd5); step(1'b1, 3'd5);
    chk("rst_lap_state", state, 0);
    chk("rst_lap_wrap", wrap_pulse, 0);
    for (int i = 0; i <= 7; i++) step(1'b0, 3'(i));
    step(1'b0, 3'd3);
    chk("clean_lap", lap_count, 1);
    chk("clean_wrap", wrap_pulse, 1);
    chk("clean_sticky", err_sticky, 0);

    // lap saturation: 259 laps
    step(1'b1, 3'd0);
    for (int i = 0; i <= 7; i++) step(1'b0, 3'(i));
    for (int k = 0; k < 259; k++) begin
      step(1'b0, 3'd3);
      chk("sat_wrap", wrap_pulse, 1);
      for (int i = 4; i <= 7; i++) step(1'b0, 3'(i));
    end
    chk("sat_lap", lap_count, 255);

    // resync sequences
    step(1'b1, 3'd0); step(1'b1, 3'd0);
    step(1'b0, 3'd0); step(1'b0, 3'd1); step(1'b0, 3'd2); step(1'b0, 3'd5);
    chk("rs_enter", state, 2);
    step(1'b0, 3'd6); step(1'b0, 3'd7); step(1'b0, 3'd3); step(1'b0, 3'd4);
`ifdef COUNT_SEQ_CHECKER_RESYNC_EN
    chk("rs_exit", state, 1);
`else
    chk("rs_exit", state, 2);
`endif
    chk("rs_sticky", err_sticky, 1);
    chk("rs_nowrap", wrap_pulse, 0);
    step(1'b0, 3'd6); step(1'b0, 3'd7); step(1'b0, 3'd3); step(1'b0, 3'd4);
    step(1'b0, 3'd6); step(1'b0, 3'd7); step(1'b0, 3'd3); step(1'b0, 3'd4);
    chk("rs_broken", state, 2);
`ifdef COUNT_SEQ_CHECKER_RESYNC_EN
    chk("rs_errc2", err_count, 2);
    p = 3'd4;
    for (int i = 0; i < 4; i++) begin p = nx(p); step(1'b0, p); end
    chk("rs_run", state, 1);
    for (int k = 0; k < 20; k++) begin
      step(1'b0, p);
      for (int i = 0; i < 4; i++) begin p = nx(p); step(1'b0, p); end
    end
    chk("errc_sat", err_count, 15);
    step(1'b0, p);
    chk("errc_hold", err_count, 15);
`endif
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/count_seq_checker.md
Name: count_seq_checker

Overview:
- Downstream consumer of the 3-bit FSM counter output (0..7, then wrap to 3, repeat).
- Samples the count every clock, checks each transition against the legal sequence and reports laps (MAX->WRAP transitions) and sequence errors.
- Used as a live monitor next to the counter and as a self-checking element in benches.

Parameters:
- WIDTH, 3, count bus width
- MAX_VAL, 7, highest legal count; the value after it is WRAP_VAL
- WRAP_VAL, 3, value following MAX_VAL
- LAP_W, 8, width of lap counter (saturating)
- ERR_W, 4, width of error counter (saturating)
- RESYNC_LEN, 4, consecutive legal transitions needed to leave ERROR (optional feature only)

Ports:
- clk  in  1  system clock, all logic on rising edge
- rst  in  1  synchronous, active-high reset
- count  in  WIDTH  counter value under check
- state  out  2  FSM state: 0=IDLE, 1=RUN, 2=ERROR
- wrap_pulse  out  1  one-cycle pulse per legal MAX_VAL->WRAP_VAL transition
- lap_count  out  LAP_W  number of legal wraps, saturates at all-ones
- err  out  1  high while state==ERROR
- err_sticky  out  1  set on first error, cleared only by rst
- err_count  out  ERR_W  number of RUN/IDLE->ERROR entries, saturates at all-ones

Behaviour:
- One clock, rst synchronous active-high; all outputs registered.
- Reset (rst high at an edge): state=IDLE, prev_q=0, wrap_pulse=0, lap_count=0, err=0, err_sticky=0, err_count=0, good run counter=0. Reset overrides every other event, including mid-lap or mid-ERROR.
- exp = (prev_q==MAX_VAL) ? WRAP_VAL : prev_q+1, computed in WIDTH bits.
- IDLE: at first edge with rst low, sample count. count==0 -> RUN. Otherwise -> ERROR: err_count+1, err_sticky=1. prev_q<=count in both cases.
- RUN:
  - count==exp: stay in RUN, prev_q<=count.
  - If additionally prev_q==MAX_VAL: wrap_pulse=1 for exactly the next cycle, lap_count+1 (saturating).
  - count!=exp: -> ERROR, err_count+1 (saturating), err_sticky=1, prev_q<=count, no wrap_pulse, lap_count held.
- ERROR: prev_q<=count every cycle; no laps counted; err_count not incremented again while in ERROR. Exit only via rst, unless the optional feature is compiled in.
- Latency: outputs reflect the transition sampled at edge N from edge N onward (visible in cycle N+1).
- A held (stalled) count is illegal: count==prev_q in RUN is an error.
- Saturation: lap_count stays at 2^LAP_W-1 and err_count stays at 2^ERR_W-1; wrap_pulse still fires after lap_count saturates.
- wrap_pulse is never high in IDLE or ERROR, and never high for two consecutive cycles.

Optional Feature:
- Macro: COUNT_SEQ_CHECKER_RESYNC_EN.
- Defined: in ERROR, a good-run counter counts consecutive transitions with count==exp(prev_q). Any illegal transition clears it to 0. When it reaches RESYNC_LEN, go to RUN and clear it. err_sticky stays set. A later error re-enters ERROR and increments err_count. The MAX->WRAP transition that completes a resync does not pulse wrap_pulse.
- Undefined: ERROR is terminal until rst; no good-run counter is synthesised.

Decomposition:
- Shared package: state encoding constants (ST_IDLE=0, ST_RUN=1, ST_ERROR=2) and a default MAX_VAL/WRAP_VAL constant pair shared with the counter block.
- One natural sub-module: sat_counter, a parameterised width saturating incrementer with sync clear. Instantiate it for lap_count, err_count and the resync good-run counter.

Test Plan:
- rst high 4 cycles, then low, count driven 0,1,..,7,3,4,..,7,3 -> state IDLE->RUN; wrap_pulse exactly 2 pulses, one cycle after each 7->3 sample; lap_count=2; err=0; err_count=0.
- In RUN at count=5, drive 7 instead of 6 -> state=ERROR next cycle; err=1; err_sticky=1; err_count=1; further samples give no wrap_pulse and leave lap_count unchanged.
- First post-reset sample=2 -> ERROR directly from IDLE; err_count=1.
- rst asserted 2 cycles mid-lap (count=5) and in ERROR -> all outputs return to reset values; a following clean 0..7,3 sequence gives lap_count=1, err_sticky=0.
- Drive 2^LAP_W+3 legal laps -> lap_count=255 and holds; wrap_pulse continues each lap. Force 20 error/rst-free re-entries (resync build) -> err_count=15 and holds.
- With COUNT_SEQ_CHECKER_RESYNC_EN: after an error, 4 legal transitions -> RUN on the 4th edge, err_sticky remains 1; with 3 legal, 1 illegal, then 3 legal transitions -> still ERROR. Without the macro, the same stimulus keeps state=ERROR.
